// File: rtl/mem_arb_pkg.sv
// Shared constants for the fetch/data memory arbiter: FSM encoding, port ids and
// the timeout counter width.
package mem_arb_pkg;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] IBUSY = 2'd1;
    localparam logic [1:0] DBUSY = 2'd2;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int TO_W = 8;
endpackage

// File: rtl/mem_arbiter_timeout_counter.sv
// Busy-cycle counter for the arbiter; expired is high while the count sits at limit-1,
// which is the last cycle an access may wait before it is aborted.
module arb_timeout_counter
    import mem_arb_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            en,
    input  logic [TO_W-1:0] limit,
    output logic            expired
);
    logic [TO_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

    assign expired = (count == limit - 1'b1);
endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-ported unified memory, with a per-access
// timeout abort. Define ARB_ROUND_ROBIN_EN for round-robin instead of fixed data priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_adr,
    output logic          i_ack,
    output logic          i_err,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_adr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic          d_err,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);
    logic [1:0] state;
    logic       i_ok, d_ok;
    logic       grant_i, grant_d;
    logic       busy, done, expired;

    // A port in its ack cycle still holds req; it must not be served twice.
    assign i_ok = i_req & ~i_ack;
    assign d_ok = d_req & ~d_ack;

`ifdef ARB_ROUND_ROBIN_EN
    logic last;

    always_comb begin
        grant_d = d_ok & (~i_ok | (last == PORT_I));
        grant_i = i_ok & ~grant_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last <= PORT_D;
        else if (state == IDLE && grant_d)
            last <= PORT_D;
        else if (state == IDLE && grant_i)
            last <= PORT_I;
    end
`else
    assign grant_d = d_ok;
    assign grant_i = i_ok & ~d_ok;
`endif

    assign busy = (state == IBUSY) | (state == DBUSY);
    assign done = busy & (mem_ready | expired);

    arb_timeout_counter u_to (
        .clk     (clk),
        .reset   (reset),
        .clr     (~busy | done),
        .en      (busy & ~mem_ready),
        .limit   (TO_W'(TIMEOUT)),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            i_ack     <= 1'b0;
            i_err     <= 1'b0;
            i_rdata   <= '0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
        end else begin
            i_ack <= 1'b0;
            i_err <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_adr   <= d_adr;
                        mem_wdata <= d_wdata;
                        state     <= DBUSY;
                    end else if (grant_i) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_adr   <= i_adr;
                        mem_wdata <= '0;
                        state     <= IBUSY;
                    end
                end
                IBUSY, DBUSY: begin
                    // mem_ready on the limit cycle completes normally.
                    if (done) begin
                        if (state == IBUSY) begin
                            i_ack   <= 1'b1;
                            i_err   <= ~mem_ready;
                            i_rdata <= mem_ready ? mem_rdata : '0;
                        end else begin
                            d_ack   <= 1'b1;
                            d_err   <= ~mem_ready;
                            d_rdata <= mem_ready ? mem_rdata : '0;
                        end
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_adr   <= '0;
                        mem_wdata <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for latency, ordering, timeout and reset.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_adr = '0;
    logic          i_ack, i_err;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_adr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack, d_err;
    logic [DW-1:0] d_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_adr(i_adr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: ready after lat wait cycles of mem_req; lat >= TO means never.
    int lat = 0;
    int wcnt = 0;
    initial forever begin
        @(negedge clk);
        if (mem_req) begin
            mem_ready = (wcnt == lat);
            wcnt++;
        end else begin
            mem_ready = 1'b0;
            wcnt = 0;
        end
    end

    // Log of memory accesses as they start.
    int          acc_cyc[$];
    logic [31:0] acc_adr[$];
    logic [31:0] acc_wd[$];
    logic        acc_we[$];
    logic        prev_req = 1'b0;
    initial forever begin
        @(negedge clk);
        if (mem_req && !prev_req) begin
            acc_cyc.push_back(cyc);
            acc_adr.push_back(mem_adr);
            acc_wd.push_back(mem_wdata);
            acc_we.push_back(mem_we);
        end
        prev_req = mem_req;
    end

    // Model: which port owns the memory (0 none, 1 fetch, 2 data) and how long it has waited.
    int          m_port, m_cnt, m_last;
    logic        e_req, e_we, e_ia, e_ie, e_da, e_de;
    logic [31:0] e_adr, e_wd, e_ird, e_drd;

    task automatic m_reset();
        m_port = 0; m_cnt = 0; m_last = 2;
        e_req = 0; e_we = 0; e_ia = 0; e_ie = 0; e_da = 0; e_de = 0;
        e_adr = 0; e_wd = 0; e_ird = 0; e_drd = 0;
    endtask

    task automatic m_step();
        bit iw, dw;
        int pick;
        iw = i_req && !e_ia;
        dw = d_req && !e_da;
        e_ia = 0; e_ie = 0; e_da = 0; e_de = 0;
        if (m_port == 0) begin
            pick = 0;
            if (iw && dw) begin
`ifdef ARB_ROUND_ROBIN_EN
                pick = (m_last == 2) ? 1 : 2;
`else
                pick = 2;
`endif
            end else if (dw) pick = 2;
            else if (iw) pick = 1;
            m_cnt = 0;
            if (pick == 2) begin
                e_req = 1; e_we = d_we; e_adr = d_adr; e_wd = d_wdata;
            end else if (pick == 1) begin
                e_req = 1; e_we = 0; e_adr = i_adr; e_wd = 0;
            end
            if (pick != 0) begin
                m_port = pick;
                m_last = pick;
            end
        end else if (mem_ready || m_cnt == TO - 1) begin
            if (m_port == 1) begin
                e_ia = 1; e_ie = !mem_ready; e_ird = mem_ready ? mem_rdata : 0;
            end else begin
                e_da = 1; e_de = !mem_ready; e_drd = mem_ready ? mem_rdata : 0;
            end
            e_req = 0; e_we = 0; e_adr = 0; e_wd = 0;
            m_port = 0;
        end else begin
            m_cnt++;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) m_reset();
            else m_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on && !reset) begin
            tests++;
            if ({mem_req, mem_we, mem_adr, mem_wdata, i_ack, i_err, i_rdata, d_ack, d_err, d_rdata} !==
                {e_req, e_we, e_adr, e_wd, e_ia, e_ie, e_ird, e_da, e_de, e_drd}) begin
                fails++;
                $display("FAIL model cyc %0d: got req=%b we=%b adr=%h wd=%h ia=%b ie=%b ird=%h da=%b de=%b drd=%h want req=%b we=%b adr=%h wd=%h ia=%b ie=%b ird=%h da=%b de=%b drd=%h",
                         cyc, mem_req, mem_we, mem_adr, mem_wdata, i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
                         e_req, e_we, e_adr, e_wd, e_ia, e_ie, e_ird, e_da, e_de, e_drd);
            end
        end
    end

    task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_ack(input bit dport, output int c);
        c = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (dport ? d_ack : i_ack) begin
                c = cyc;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL %s ack timeout: got none want ack within 100 cycles", dport ? "data" : "fetch");
    endtask

    int s, c, ci, cd, n0;

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);
        chk_eq("reset ctl", {26'd0, mem_req, mem_we, i_ack, i_err, d_ack, d_err}, 32'd0);
        chk_eq("reset adr", mem_adr, 32'd0);
        chk_eq("reset rdata", i_rdata | d_rdata, 32'd0);

        // zero-wait load
        lat = 0; mem_rdata = 32'd21; n0 = acc_adr.size();
        d_req = 1; d_we = 0; d_adr = 32'h18; s = cyc;
        wait_ack(1, c);
        chk_eq("load latency", c - s, 32'd2);
        chk_eq("load rdata", d_rdata, 32'd21);
        chk_eq("load err", {31'd0, d_err}, 32'd0);
        @(negedge clk); d_req = 0;
        chk_eq("load adr", acc_adr[n0], 32'h18);
        chk_eq("load we", {31'd0, acc_we[n0]}, 32'd0);

        // collision: store vs fetch
        mem_rdata = 32'h99; n0 = acc_adr.size();
        i_req = 1; i_adr = 32'h4; d_req = 1; d_we = 1; d_adr = 32'h54; d_wdata = 32'd7;
        fork
            begin wait_ack(1, cd); @(negedge clk); d_req = 0; d_we = 0; end
            begin wait_ack(0, ci); @(negedge clk); i_req = 0; end
        join
        chk_eq("collision count", acc_adr.size(), n0 + 2);
`ifdef ARB_ROUND_ROBIN_EN
        chk_eq("rr first adr", acc_adr[n0], 32'h4);
        chk_eq("rr second adr", acc_adr[n0+1], 32'h54);
        chk_eq("rr second we/wd", {acc_we[n0+1], acc_wd[n0+1][30:0]}, {1'b1, 31'd7});
`else
        chk_eq("prio first adr", acc_adr[n0], 32'h54);
        chk_eq("prio first we/wd", {acc_we[n0], acc_wd[n0][30:0]}, {1'b1, 31'd7});
        chk_eq("prio second adr", acc_adr[n0+1], 32'h4);
        chk_eq("prio second we", {31'd0, acc_we[n0+1]}, 32'd0);
`endif
        chk_eq("store captures rdata", d_rdata, 32'h99);

        // fetch timeout
        lat = 255; n0 = acc_adr.size();
        @(negedge clk); i_req = 1; i_adr = 32'h100;
        wait_ack(0, c);
        chk_eq("timeout cycles", c - acc_cyc[n0], TO);
        chk_eq("timeout err", {31'd0, i_err}, 32'd1);
        chk_eq("timeout rdata", i_rdata, 32'd0);
        @(negedge clk); i_req = 0;
        chk_eq("timeout mem_req", {31'd0, mem_req}, 32'd0);

        // data timeout
        n0 = acc_adr.size();
        d_req = 1; d_we = 0; d_adr = 32'h120;
        wait_ack(1, c);
        chk_eq("d timeout cycles", c - acc_cyc[n0], TO);
        chk_eq("d timeout err/rdata", {d_err, d_rdata[30:0]}, {1'b1, 31'd0});
        @(negedge clk); d_req = 0;

        // ready on the limit cycle
        lat = TO - 1; mem_rdata = 32'h5a5a; n0 = acc_adr.size();
        i_req = 1; i_adr = 32'h200;
        wait_ack(0, c);
        chk_eq("limit cycles", c - acc_cyc[n0], TO);
        chk_eq("limit err", {31'd0, i_err}, 32'd0);
        chk_eq("limit rdata", i_rdata, 32'h5a5a);
        @(negedge clk); i_req = 0;

        // reset while in DBUSY
        lat = 255;
        @(negedge clk); d_req = 1; d_we = 1; d_adr = 32'h300; d_wdata = 32'hdead;
        repeat (3) @(negedge clk);
        chk_eq("pre-reset busy", {31'd0, mem_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk_eq("async reset ctl", {28'd0, mem_req, mem_we, i_ack, d_ack}, 32'd0);
        chk_eq("async reset adr/wd", mem_adr | mem_wdata, 32'd0);
        @(negedge clk); d_req = 0; d_we = 0;
        @(negedge clk); reset = 1'b0;

        // back-to-back fetches; first access after reset also proves IDLE
        lat = 0; mem_rdata = 32'h11; n0 = acc_adr.size();
        @(negedge clk); i_req = 1; i_adr = 32'h40; s = cyc;
        wait_ack(0, ci);
        chk_eq("b2b first latency", ci - s, 32'd2);
        chk_eq("b2b first rdata", i_rdata, 32'h11);
        i_adr = 32'h44; mem_rdata = 32'h22;
        wait_ack(0, c);
        @(negedge clk); i_req = 0;
        chk_eq("b2b count", acc_adr.size(), n0 + 2);
        // held req is excluded in the ack cycle, granted the next, so memory sees it one cycle later
        chk_eq("b2b second start", acc_cyc[n0+1], ci + 2);
        chk_eq("b2b second adr", acc_adr[n0+1], 32'h44);
        chk_eq("b2b second rdata", i_rdata, 32'h22);
        repeat (3) @(negedge clk);
        chk_eq("b2b no extra", acc_adr.size(), n0 + 2);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
